// File: rtl/hs_npu_mem_bridge.sv
// hs_npu_mem_bridge: NPU line requests served as sequential 32-bit Avalon-MM word transfers.
// Optional read watchdog enabled by defining HS_NPU_MEM_BRIDGE_TIMEOUT_EN.
module hs_npu_mem_bridge #(
  parameter int WORDS_PER_LINE = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          npu_read_req_i,
  input  logic                          npu_write_req_i,
  input  logic [31:0]                   npu_address_i,
  input  logic [32*WORDS_PER_LINE-1:0]  npu_wdata_i,
  output logic [32*WORDS_PER_LINE-1:0]  npu_rdata_o,
  output logic                          npu_valid_o,
  output logic [31:0]                   avm_address_o,
  output logic                          avm_read_o,
  output logic                          avm_write_o,
  output logic [31:0]                   avm_writedata_o,
  input  logic                          avm_waitrequest_i,
  input  logic [31:0]                   avm_readdata_i,
  input  logic                          avm_readdatavalid_i,
  output logic                          err_o
);
  localparam int CW = $clog2(WORDS_PER_LINE + 1);
  localparam int LW = 32 * WORDS_PER_LINE;
  if (WORDS_PER_LINE < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("hs_npu_mem_bridge: WORDS_PER_LINE and TIMEOUT_CYCLES must be >= 1");
  end
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR, DONE} state_t;
  state_t r_state, w_next;
  logic [31:0]   r_addr, w_word_addr;
  logic [LW-1:0] r_wdata, r_shadow, r_rdata, w_line;
  logic [CW-1:0] r_issue_cnt, r_recv_cnt;
  logic          w_rd_phase, w_beat, w_accept, w_last_issue, w_last_beat, w_all_recv, w_timeout;
  assign w_rd_phase   = (r_state == RD_ISSUE) || (r_state == RD_WAIT);
  assign w_beat       = w_rd_phase && avm_readdatavalid_i && (r_recv_cnt < CW'(WORDS_PER_LINE));
  assign w_accept     = ((r_state == RD_ISSUE) || (r_state == WR)) && !avm_waitrequest_i;
  assign w_last_issue = w_accept && (r_issue_cnt == CW'(WORDS_PER_LINE - 1));
  assign w_last_beat  = w_beat && (r_recv_cnt == CW'(WORDS_PER_LINE - 1));
  assign w_all_recv   = (r_recv_cnt + CW'(w_beat)) == CW'(WORDS_PER_LINE);
  assign w_word_addr  = r_addr + {r_issue_cnt, 2'b00};
  assign npu_rdata_o  = r_rdata;
  // Shadow line with the current beat merged, so completion can copy it on the same edge.
  always_comb begin
    w_line = r_shadow;
    if (w_beat) w_line[32*32'(r_recv_cnt) +: 32] = avm_readdata_i;
  end
  always_comb begin
    w_next          = r_state;
    npu_valid_o     = 1'b0;
    avm_read_o      = 1'b0;
    avm_write_o     = 1'b0;
    avm_address_o   = '0;
    avm_writedata_o = '0;
    case (r_state)
      IDLE: w_next = npu_write_req_i ? WR : (npu_read_req_i ? RD_ISSUE : IDLE);
      RD_ISSUE: begin
        avm_read_o    = 1'b1;
        avm_address_o = w_word_addr;
        if (w_last_issue) w_next = w_all_recv ? DONE : RD_WAIT;
      end
      RD_WAIT: if (w_last_beat) w_next = DONE;
      WR: begin
        avm_write_o     = 1'b1;
        avm_address_o   = w_word_addr;
        avm_writedata_o = r_wdata[32*32'(r_issue_cnt) +: 32];
        if (w_last_issue) w_next = DONE;
      end
      DONE: begin
        npu_valid_o = 1'b1;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (w_timeout) w_next = DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_shadow    <= '0;
      r_rdata     <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        r_addr      <= {npu_address_i[31:2], 2'b00};
        r_wdata     <= npu_wdata_i;
        r_shadow    <= '0;
        r_issue_cnt <= '0;
        r_recv_cnt  <= '0;
      end else begin
        if (w_accept) r_issue_cnt <= r_issue_cnt + 1'b1;
        if (w_beat) begin
          r_shadow   <= w_line;
          r_recv_cnt <= r_recv_cnt + 1'b1;
        end
      end
      if (w_rd_phase && w_next == DONE) r_rdata <= w_line;
    end
  end
`ifdef HS_NPU_MEM_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_wd;
  logic          r_err;
  assign w_timeout = w_rd_phase && (r_wd == TW'(TIMEOUT_CYCLES));
  assign err_o     = r_err;
  // Missing words are already zero in the shadow line, so the timeout just completes the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == IDLE || w_beat) r_wd <= '0;
      else if (w_rd_phase && r_issue_cnt != r_recv_cnt && !w_timeout) r_wd <= r_wd + 1'b1;
      if (w_timeout) r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err_o     = 1'b0;
`endif
endmodule

// File: tb/tb_hs_npu_mem_bridge.sv
// tb_hs_npu_mem_bridge: scoreboard bench with a behavioural Avalon slave and a memory reference model.
module tb_hs_npu_mem_bridge;
  localparam int WPL = 2;
  localparam int LW  = 32 * WPL;
`ifdef HS_NPU_MEM_BRIDGE_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif
  logic          clk = 0, rst = 1;
  logic          npu_read_req_i = 0, npu_write_req_i = 0;
  logic [31:0]   npu_address_i = 0;
  logic [LW-1:0] npu_wdata_i = '0, npu_rdata_o;
  logic          npu_valid_o, avm_read_o, avm_write_o, err_o;
  logic [31:0]   avm_address_o, avm_writedata_o, avm_readdata_i = 0;
  logic          avm_waitrequest_i = 0, avm_readdatavalid_i = 0;

  always #5 clk = ~clk;

  hs_npu_mem_bridge #(.WORDS_PER_LINE(WPL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .npu_read_req_i(npu_read_req_i), .npu_write_req_i(npu_write_req_i),
    .npu_address_i(npu_address_i), .npu_wdata_i(npu_wdata_i),
    .npu_rdata_o(npu_rdata_o), .npu_valid_o(npu_valid_o),
    .avm_address_o(avm_address_o), .avm_read_o(avm_read_o), .avm_write_o(avm_write_o),
    .avm_writedata_o(avm_writedata_o), .avm_waitrequest_i(avm_waitrequest_i),
    .avm_readdata_i(avm_readdata_i), .avm_readdatavalid_i(avm_readdatavalid_i),
    .err_o(err_o)
  );

  typedef struct packed {logic wr; logic [31:0] a; logic [31:0] d;} xfer_t;
  typedef struct {int due; logic [31:0] d;} beat_t;
  xfer_t         exp_x[$];
  logic [LW-1:0] exp_l[$];
  beat_t         pend[$];
  logic [31:0]   mem[logic [31:0]];
  logic [31:0]   ref_mem[logic [31:0]];
  int            n_chk = 0, n_fail = 0, n_valid = 0, cyc = 0, last_due = 0;
  int            stall_pct = 0, lat_min = 1, lat_max = 1, wait_n = 0, slv_acc = 0, s_due;
  bit            drop_rest = 0;
  logic [LW-1:0] last_line = '0;

  function automatic logic [31:0] init_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] ref_word(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic void chk(string n, logic [LW-1:0] act, logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endfunction

  task automatic seed(logic [31:0] a, logic [31:0] d);
    mem[a] = d;
    ref_mem[a] = d;
  endtask

  // Reference model: word i of a line lives at (addr & ~3) + 4*i, wrapping at 2^32.
  task automatic push_exp(bit wr, logic [31:0] a, logic [LW-1:0] d, int live);
    logic [31:0]   b = {a[31:2], 2'b00};
    logic [LW-1:0] nl = '0;
    for (int i = 0; i < WPL; i++) begin
      logic [31:0] wa;
      wa = b + 32'(4 * i);
      exp_x.push_back('{wr, wa, wr ? d[32*i +: 32] : 32'h0});
      if (wr) ref_mem[wa] = d[32*i +: 32];
      else if (i < live) nl[32*i +: 32] = ref_word(wa);
    end
    if (!wr) last_line = nl;
    exp_l.push_back(last_line);
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (npu_valid_o) begin
        lat = t;
        return;
      end
    end
    n_chk++;
    n_fail++;
    $display("FAIL wait_valid: no npu_valid_o within 400 cycles");
  endtask

  task automatic txn(bit wr, logic [31:0] a, logic [LW-1:0] d, int live, output int lat);
    int v0;
    @(posedge clk); #1;
    v0 = n_valid;
    push_exp(wr, a, d, live);
    npu_address_i = a;
    npu_wdata_i = d;
    npu_write_req_i = wr;
    npu_read_req_i = !wr;
    wait_valid(lat);
    npu_write_req_i = 0;
    npu_read_req_i = 0;
    repeat (3) @(negedge clk);
    chk("one_pulse", LW'(n_valid - v0), LW'(1));
  endtask

  // Slave: records accepts at negedge, drives the next cycle's inputs just after posedge.
  initial forever begin
    @(negedge clk);
    if (avm_read_o && !avm_waitrequest_i) begin
      if (!(drop_rest && slv_acc != 0)) begin
        s_due = cyc + int'($urandom_range(lat_max, lat_min));
        if (s_due <= last_due) s_due = last_due + 1;
        last_due = s_due;
        pend.push_back('{s_due, mem.exists(avm_address_o) ? mem[avm_address_o] : init_word(avm_address_o)});
      end
      slv_acc++;
    end
    if (avm_write_o && !avm_waitrequest_i) mem[avm_address_o] = avm_writedata_o;
    @(posedge clk); #1;
    cyc++;
    avm_readdatavalid_i = 0;
    avm_readdata_i = $urandom;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      avm_readdatavalid_i = 1;
      avm_readdata_i = pend[0].d;
      void'(pend.pop_front());
    end
    if (wait_n > 0 && (avm_read_o || avm_write_o)) begin
      avm_waitrequest_i = 1;
      wait_n--;
    end else avm_waitrequest_i = ($urandom_range(99) < stall_pct);
  end

  // Monitor: compares every accepted transfer and every completion pulse against the scoreboard.
  logic        p_stall = 0, p_rd = 0, p_wr = 0;
  logic [31:0] p_a = 0, p_d = 0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      p_stall = 0;
      continue;
    end
    if (avm_read_o || avm_write_o) chk("strobe_excl", LW'(avm_read_o & avm_write_o), '0);
    if (p_stall) begin
      chk("hold_strobe", LW'({avm_read_o, avm_write_o}), LW'({p_rd, p_wr}));
      chk("hold_addr", LW'(avm_address_o), LW'(p_a));
      if (p_wr) chk("hold_data", LW'(avm_writedata_o), LW'(p_d));
    end
    if ((avm_read_o || avm_write_o) && !avm_waitrequest_i) begin
      if (exp_x.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_xfer: addr %h wr %b", avm_address_o, avm_write_o);
      end else begin
        xfer_t x;
        x = exp_x.pop_front();
        chk("xfer_kind", LW'(avm_write_o), LW'(x.wr));
        chk("xfer_addr", LW'(avm_address_o), LW'(x.a));
        if (x.wr) chk("xfer_data", LW'(avm_writedata_o), LW'(x.d));
      end
    end
    if (npu_valid_o) begin
      n_valid++;
      if (exp_l.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: rdata %h", npu_rdata_o);
      end else begin
        chk("line", npu_rdata_o, exp_l.pop_front());
        chk("xfers_done", LW'(exp_x.size()), '0);
      end
    end
    p_stall = (avm_read_o || avm_write_o) && avm_waitrequest_i;
    p_rd = avm_read_o;
    p_wr = avm_write_o;
    p_a = avm_address_o;
    p_d = avm_writedata_o;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, v0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", LW'(npu_valid_o), '0);
    chk("rst_read", LW'(avm_read_o), '0);
    chk("rst_write", LW'(avm_write_o), '0);
    chk("rst_addr", LW'(avm_address_o), '0);
    chk("rst_wdata", LW'(avm_writedata_o), '0);
    chk("rst_rdata", npu_rdata_o, '0);
    chk("rst_err", LW'(err_o), '0);
    @(posedge clk); #1 rst = 0;

    seed(32'h100, 32'hA);
    seed(32'h104, 32'hB);
    txn(0, 32'h100, '0, WPL, lat);
    chk("rd_latency", LW'(lat), LW'(4));
    chk("rd_line_direct", npu_rdata_o, {32'hB, 32'hA});

    wait_n = 3;
    txn(1, 32'h203, {32'h22, 32'h11}, WPL, lat);
    chk("wr_latency_stall", LW'(lat), LW'(6));
    chk("mem_200", LW'(mem[32'h200]), LW'(32'h11));
    chk("mem_204", LW'(mem[32'h204]), LW'(32'h22));
    chk("rdata_held", npu_rdata_o, {32'hB, 32'hA});

    txn(1, 32'h400, {32'hCAFE_0001, 32'hBEEF_0000}, WPL, lat);
    chk("wr_latency", LW'(lat), LW'(WPL + 1));

    @(posedge clk); #1;
    v0 = n_valid;
    push_exp(1, 32'h500, {32'h5555_0001, 32'h5555_0000}, WPL);
    npu_address_i = 32'h500;
    npu_wdata_i = {32'h5555_0001, 32'h5555_0000};
    npu_write_req_i = 1;
    npu_read_req_i = 1;
    wait_valid(lat);
    npu_write_req_i = 0;
    chk("both_write_first", LW'(lat), LW'(WPL + 1));
    #1 push_exp(0, 32'h500, '0, WPL);
    wait_valid(lat);
    npu_read_req_i = 0;
    repeat (3) @(negedge clk);
    chk("both_pulses", LW'(n_valid - v0), LW'(2));

    seed(32'hFFFF_FFFC, 32'h1234_FFFC);
    seed(32'h0000_0000, 32'h1234_0000);
    txn(0, 32'hFFFF_FFFC, '0, WPL, lat);
    chk("wrap_line", npu_rdata_o, {32'h1234_0000, 32'h1234_FFFC});

    lat_min = 3;
    lat_max = 3;
    @(posedge clk); #1;
    v0 = n_valid;
    push_exp(0, 32'h600, '0, WPL);
    npu_address_i = 32'h600;
    npu_read_req_i = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    npu_read_req_i = 0;
    @(posedge clk); #1 rst = 0;
    exp_x.delete();
    exp_l.delete();
    last_line = '0;
    repeat (10) @(negedge clk);
    chk("rst_mid_no_pulse", LW'(n_valid - v0), '0);
    chk("rst_mid_rdata", npu_rdata_o, '0);
    chk("rst_mid_idle", LW'({avm_read_o, avm_write_o}), '0);
    chk("rst_mid_pend", LW'(pend.size()), '0);

`ifdef HS_NPU_MEM_BRIDGE_TIMEOUT_EN
    lat_min = 1;
    lat_max = 1;
    seed(32'h300, 32'h5);
    slv_acc = 0;
    drop_rest = 1;
    chk("err_before", LW'(err_o), '0);
    txn(0, 32'h300, '0, 1, lat);
    drop_rest = 0;
    chk("to_line", npu_rdata_o, {32'h0, 32'h5});
    chk("to_err", LW'(err_o), LW'(1));
`endif

    for (int n = 0; n < 40; n++) begin
      logic [31:0]   a;
      logic [LW-1:0] d;
      stall_pct = $urandom_range(40);
      lat_min = 1;
      lat_max = $urandom_range(4, 1);
      a = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(15) : $urandom & 32'h0000_00FF;
      d = {$urandom, $urandom};
      txn(bit'($urandom_range(1)), a, d, WPL, lat);
      while (pend.size() != 0) @(posedge clk);
    end
    stall_pct = 0;
    repeat (5) @(negedge clk);
    chk("sb_lines_empty", LW'(exp_l.size()), '0);
    chk("sb_xfers_empty", LW'(exp_x.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
